// File: rtl/cave_input_ctrl_pkg.sv
// Shared types and constants for the Cave player-input front end:
// scancodes, joystick bit positions, coin FSM states and the per-player bundle.
package cave_input_pkg;

  // Extended (E0-prefixed) scancodes: cursor keys
  localparam logic [7:0] ScArrUp    = 8'h75;
  localparam logic [7:0] ScArrDown  = 8'h72;
  localparam logic [7:0] ScArrLeft  = 8'h6B;
  localparam logic [7:0] ScArrRight = 8'h74;

  localparam logic [7:0] ScCtrl   = 8'h14;
  localparam logic [7:0] ScAlt    = 8'h11;
  localparam logic [7:0] ScSpace  = 8'h29;
  localparam logic [7:0] ScLShift = 8'h12;
  localparam logic [7:0] ScKey1   = 8'h16;
  localparam logic [7:0] ScKey5   = 8'h2E;
  localparam logic [7:0] ScKeyP   = 8'h4D;

  localparam logic [7:0] ScKeyR = 8'h2D;
  localparam logic [7:0] ScKeyF = 8'h2B;
  localparam logic [7:0] ScKeyD = 8'h23;
  localparam logic [7:0] ScKeyG = 8'h34;
  localparam logic [7:0] ScKeyA = 8'h1C;
  localparam logic [7:0] ScKeyS = 8'h1B;
  localparam logic [7:0] ScKeyQ = 8'h15;
  localparam logic [7:0] ScKeyW = 8'h1D;
  localparam logic [7:0] ScKey2 = 8'h1E;
  localparam logic [7:0] ScKey6 = 8'h36;

  localparam int unsigned JoyRight = 0;
  localparam int unsigned JoyLeft  = 1;
  localparam int unsigned JoyDown  = 2;
  localparam int unsigned JoyUp    = 3;
  localparam int unsigned JoyB1    = 4;
  localparam int unsigned JoyStart = 8;
  localparam int unsigned JoyCoin  = 9;
  localparam int unsigned JoyPause = 10;

  typedef enum logic [1:0] {
    StIdle,
    StPulse,
    StHoldoff
  } coin_state_t;

  typedef struct packed {
    logic       up;
    logic       down;
    logic       left;
    logic       right;
    logic [3:0] buttons;
    logic       start;
    logic       coin;
    logic       pause;
  } player_t;

  function automatic player_t joy_to_player(input logic [10:0] j);
    player_t p;
    p.up      = j[JoyUp];
    p.down    = j[JoyDown];
    p.left    = j[JoyLeft];
    p.right   = j[JoyRight];
    p.buttons = j[JoyB1+:4];
    p.start   = j[JoyStart];
    p.coin    = j[JoyCoin];
    p.pause   = j[JoyPause];
    return p;
  endfunction

endpackage

// File: rtl/cave_input_ctrl_if.sv
// hps_io-facing inputs and per-player outputs of cave_input_ctrl.
// master = host/hps side, slave = the input controller.
interface cave_input_ctrl_if;
  logic [10:0] ps2_key;
  logic [31:0] joystick_0;
  logic [31:0] joystick_1;
  logic        vblank;
  logic        clear;

  logic       p0_up, p0_down, p0_left, p0_right;
  logic [3:0] p0_buttons;
  logic       p0_start, p0_coin, p0_pause;

  logic       p1_up, p1_down, p1_left, p1_right;
  logic [3:0] p1_buttons;
  logic       p1_start, p1_coin, p1_pause;

  modport master (
    output ps2_key, joystick_0, joystick_1, vblank, clear,
    input  p0_up, p0_down, p0_left, p0_right, p0_buttons, p0_start, p0_coin, p0_pause,
    input  p1_up, p1_down, p1_left, p1_right, p1_buttons, p1_start, p1_coin, p1_pause
  );

  modport slave (
    input  ps2_key, joystick_0, joystick_1, vblank, clear,
    output p0_up, p0_down, p0_left, p0_right, p0_buttons, p0_start, p0_coin, p0_pause,
    output p1_up, p1_down, p1_left, p1_right, p1_buttons, p1_start, p1_coin, p1_pause
  );
endinterface

// File: rtl/cave_input_ctrl_coin_pulse.sv
// Shapes a raw coin input into a single pulse lasting COIN_FRAMES frame ticks,
// then holds off until the input is released on a frame tick.
module coin_pulse
  import cave_input_pkg::*;
#(
  parameter int unsigned COIN_FRAMES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic tick,
  output logic coin
);

  localparam logic [3:0] LastCnt = 4'(COIN_FRAMES - 1);

  coin_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        raw_q;
  logic        rise;

  assign rise = raw & ~raw_q;

  // raw_q tracks raw even in reset so a coin held across reset exit cannot fire
  always_ff @(posedge clk) begin
    raw_q <= raw;
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (rise) begin
          state_d = StPulse;
          cnt_d   = '0;
        end
      end
      StPulse: begin
        if (tick) begin
          if (cnt_q == LastCnt) state_d = StHoldoff;
          else                  cnt_d   = cnt_q + 4'd1;
        end
      end
      StHoldoff: begin
        if (tick && !raw) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    coin = (state_q == StPulse);
  end

endmodule

// File: rtl/cave_input_ctrl.sv
// Player-input front end: PS/2 toggle decode into a held-key map, merge with
// joystick words, SOCD cleaning and frame-timed coin pulses for two players.
module cave_input_ctrl
  import cave_input_pkg::*;
#(
  parameter int unsigned COIN_FRAMES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  cave_input_ctrl_if.slave  bus
);

  logic    tog_q;
  logic    vblank_q;
  logic    ps2_evt;
  logic    tick;
  player_t key0_q, key0_d, key1_q, key1_d;
  player_t raw0, raw1;
  player_t out0_q, out0_d, out1_q, out1_d;
  logic    coin0, coin1;
  logic    unused_joy;

  assign unused_joy = ^{bus.joystick_0[31:11], bus.joystick_1[31:11]};
  assign ps2_evt    = bus.ps2_key[10] != tog_q;
  assign tick       = bus.vblank & ~vblank_q;

  always_comb begin
    key0_d = key0_q;
    key1_d = key1_q;
    if (bus.clear) begin
      key0_d = '0;
      key1_d = '0;
    end else if (ps2_evt) begin
      if (bus.ps2_key[8]) begin
        case (bus.ps2_key[7:0])
          ScArrUp:    key0_d.up    = bus.ps2_key[9];
          ScArrDown:  key0_d.down  = bus.ps2_key[9];
          ScArrLeft:  key0_d.left  = bus.ps2_key[9];
          ScArrRight: key0_d.right = bus.ps2_key[9];
          default: ;
        endcase
      end else begin
        case (bus.ps2_key[7:0])
          ScCtrl:   key0_d.buttons[0] = bus.ps2_key[9];
          ScAlt:    key0_d.buttons[1] = bus.ps2_key[9];
          ScSpace:  key0_d.buttons[2] = bus.ps2_key[9];
          ScLShift: key0_d.buttons[3] = bus.ps2_key[9];
          ScKey1:   key0_d.start      = bus.ps2_key[9];
          ScKey5:   key0_d.coin       = bus.ps2_key[9];
          ScKeyP:   key0_d.pause      = bus.ps2_key[9];
          ScKeyR:   key1_d.up         = bus.ps2_key[9];
          ScKeyF:   key1_d.down       = bus.ps2_key[9];
          ScKeyD:   key1_d.left       = bus.ps2_key[9];
          ScKeyG:   key1_d.right      = bus.ps2_key[9];
          ScKeyA:   key1_d.buttons[0] = bus.ps2_key[9];
          ScKeyS:   key1_d.buttons[1] = bus.ps2_key[9];
          ScKeyQ:   key1_d.buttons[2] = bus.ps2_key[9];
          ScKeyW:   key1_d.buttons[3] = bus.ps2_key[9];
          ScKey2:   key1_d.start      = bus.ps2_key[9];
          ScKey6:   key1_d.coin       = bus.ps2_key[9];
          default: ;
        endcase
      end
    end
  end

  // Player 1 pause has no key binding, so key1_q.pause stays 0
  assign raw0 = key0_q | joy_to_player(bus.joystick_0[10:0]);
  assign raw1 = key1_q | joy_to_player(bus.joystick_1[10:0]);

  function automatic player_t socd(input player_t r);
    player_t p;
    p      = r;
    p.coin = 1'b0;
    if (r.up && r.down) begin
      p.up   = 1'b0;
      p.down = 1'b0;
    end
    if (r.left && r.right) begin
      p.left  = 1'b0;
      p.right = 1'b0;
    end
    return p;
  endfunction

  always_comb begin
    out0_d = socd(raw0);
    out1_d = socd(raw1);
  end

  always_ff @(posedge clk) begin
    tog_q <= bus.ps2_key[10];
    if (!rst_n) begin
      vblank_q <= 1'b0;
      key0_q   <= '0;
      key1_q   <= '0;
      out0_q   <= '0;
      out1_q   <= '0;
    end else begin
      vblank_q <= bus.vblank;
      key0_q   <= key0_d;
      key1_q   <= key1_d;
      out0_q   <= out0_d;
      out1_q   <= out1_d;
    end
  end

  coin_pulse #(
    .COIN_FRAMES(COIN_FRAMES)
  ) u_coin0 (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (raw0.coin),
    .tick (tick),
    .coin (coin0)
  );

  coin_pulse #(
    .COIN_FRAMES(COIN_FRAMES)
  ) u_coin1 (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (raw1.coin),
    .tick (tick),
    .coin (coin1)
  );

  assign bus.p0_up      = out0_q.up;
  assign bus.p0_down    = out0_q.down;
  assign bus.p0_left    = out0_q.left;
  assign bus.p0_right   = out0_q.right;
  assign bus.p0_buttons = out0_q.buttons;
  assign bus.p0_start   = out0_q.start;
  assign bus.p0_coin    = coin0;
  assign bus.p0_pause   = out0_q.pause;

  assign bus.p1_up      = out1_q.up;
  assign bus.p1_down    = out1_q.down;
  assign bus.p1_left    = out1_q.left;
  assign bus.p1_right   = out1_q.right;
  assign bus.p1_buttons = out1_q.buttons;
  assign bus.p1_start   = out1_q.start;
  assign bus.p1_coin    = coin1;
  assign bus.p1_pause   = out1_q.pause;

endmodule
